// File: rtl/sys_arr_pkg.sv
// Shared systolic-array sizing plus the feeder's state encoding and default row gap.
package sys_arr_pkg;
   localparam int N          = 4;
   localparam int DW         = 32;
   localparam int FEEDER_GAP = 1;

   typedef enum logic [3:0] {
      IDLE,
      LOAD_W,
      LOAD_I,
      LOAD_P,
      WAIT_DRAIN,
      WAIT_SPACE,
      ISSUE_W,
      ISSUE_IP,
      GAP_S
   } feeder_state_t;
endpackage

// File: rtl/systolic_array_row_buf.sv
// N-entry row register file: one write port, one registered read port that
// returns zero whenever no read is requested.
module systolic_array_row_buf #(
   parameter int N  = 4,
   parameter int DW = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [$clog2(N)-1:0]   wr_addr,
   input  logic [N*DW-1:0]        wr_data,
   input  logic                   rd_en,
   input  logic [$clog2(N)-1:0]   rd_addr,
   output logic [N*DW-1:0]        rd_data
);
   logic [N*DW-1:0] mem_q [N];
   logic [N*DW-1:0] rd_data_d;
   logic [N*DW-1:0] rd_data_q;

   always_comb begin
      rd_data_d = '0;
      if (rd_en) rd_data_d = mem_q[rd_addr];
   end

   // Storage is never reset; only the read register has a defined reset value.
   always_ff @(posedge clk) begin
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= rd_data_d;
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/systolic_array_feeder.sv
// Buffers one tile job (optional weights, inputs, partials), waits for array
// readiness, then issues rows to the systolic array load port.
module systolic_array_feeder #(
   parameter int N   = sys_arr_pkg::N,
   parameter int DW  = sys_arr_pkg::DW,
   parameter int GAP = sys_arr_pkg::FEEDER_GAP
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_has_weights,
   input  logic                   row_valid,
   output logic                   row_ready,
   input  logic [N*DW-1:0]        row_data,
   output logic                   weight_en,
   output logic                   input_en,
   output logic                   partial_en,
   output logic [$clog2(N)-1:0]   row_in_en,
   output logic [$clog2(N)-1:0]   row_ps_en,
   output logic [N*DW-1:0]        array_in,
   output logic [N*DW-1:0]        array_in_partials,
   input  logic                   drained,
   input  logic                   fifo_has_space,
   output logic                   busy,
   output logic                   job_done
);
   import sys_arr_pkg::*;

   localparam int RW = $clog2(N);
   localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);
   localparam logic [RW-1:0] LAST = RW'(N - 1);

   feeder_state_t   state_q, state_d;
   logic            has_w_q, has_w_d;
   logic [RW-1:0]   row_cnt_q, row_cnt_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic            job_done_q, job_done_d;
   logic            weight_en_q, weight_en_d;
   logic            ip_en_q, ip_en_d;
   logic [RW-1:0]   row_in_q, row_in_d;
   logic [RW-1:0]   row_ps_q, row_ps_d;

   logic            wr_w, wr_i, wr_p;
   logic            rd_w, rd_ip;
   logic [N*DW-1:0] w_rd, i_rd, p_rd;

   always_comb begin
      state_d    = state_q;
      has_w_d    = has_w_q;
      row_cnt_d  = row_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      job_done_d = 1'b0;
      wr_w       = 1'b0;
      wr_i       = 1'b0;
      wr_p       = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && !job_done_q) begin
               has_w_d   = cmd_has_weights;
               row_cnt_d = '0;
               state_d   = cmd_has_weights ? LOAD_W : LOAD_I;
            end
         end
         LOAD_W, LOAD_I, LOAD_P: begin
            if (row_valid) begin
               wr_w      = (state_q == LOAD_W);
               wr_i      = (state_q == LOAD_I);
               wr_p      = (state_q == LOAD_P);
               row_cnt_d = row_cnt_q + 1'b1;
               if (row_cnt_q == LAST) begin
                  if (state_q == LOAD_W)      state_d = LOAD_I;
                  else if (state_q == LOAD_I) state_d = LOAD_P;
                  else                        state_d = has_w_q ? WAIT_DRAIN : WAIT_SPACE;
               end
            end
         end
         WAIT_DRAIN: if (drained)        state_d = ISSUE_W;
         WAIT_SPACE: if (fifo_has_space) state_d = ISSUE_IP;
         ISSUE_W: begin
            row_cnt_d = row_cnt_q + 1'b1;
            if (row_cnt_q == LAST) state_d = ISSUE_IP;
         end
         ISSUE_IP: begin
            if (GAP > 0) begin
               state_d   = GAP_S;
               gap_cnt_d = GW'((GAP > 0) ? GAP - 1 : 0);
            end else begin
               row_cnt_d = row_cnt_q + 1'b1;
               if (row_cnt_q == LAST) begin
                  state_d    = IDLE;
                  job_done_d = 1'b1;
               end
            end
         end
         GAP_S: begin
            if (gap_cnt_q == '0) begin
               row_cnt_d = row_cnt_q + 1'b1;
               if (row_cnt_q == LAST) begin
                  state_d    = IDLE;
                  job_done_d = 1'b1;
               end else begin
                  state_d = ISSUE_IP;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so the registered outputs line
   // up with the registered buffer read of the same row.
   always_comb begin
      rd_w        = (state_d == ISSUE_W);
      rd_ip       = (state_d == ISSUE_IP);
      weight_en_d = rd_w;
      ip_en_d     = rd_ip;
      row_in_d    = (rd_w || rd_ip) ? row_cnt_d : '0;
      row_ps_d    = rd_ip ? row_cnt_d : '0;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= IDLE;
         has_w_q     <= 1'b0;
         row_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         job_done_q  <= 1'b0;
         weight_en_q <= 1'b0;
         ip_en_q     <= 1'b0;
         row_in_q    <= '0;
         row_ps_q    <= '0;
      end else begin
         state_q     <= state_d;
         has_w_q     <= has_w_d;
         row_cnt_q   <= row_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         job_done_q  <= job_done_d;
         weight_en_q <= weight_en_d;
         ip_en_q     <= ip_en_d;
         row_in_q    <= row_in_d;
         row_ps_q    <= row_ps_d;
      end
   end

   systolic_array_row_buf #(.N(N), .DW(DW)) u_w_buf (
      .clk(clk), .rst(RST), .wr_en(wr_w), .wr_addr(row_cnt_q), .wr_data(row_data),
      .rd_en(rd_w), .rd_addr(row_cnt_d), .rd_data(w_rd));
   systolic_array_row_buf #(.N(N), .DW(DW)) u_i_buf (
      .clk(clk), .rst(RST), .wr_en(wr_i), .wr_addr(row_cnt_q), .wr_data(row_data),
      .rd_en(rd_ip), .rd_addr(row_cnt_d), .rd_data(i_rd));
   systolic_array_row_buf #(.N(N), .DW(DW)) u_p_buf (
      .clk(clk), .rst(RST), .wr_en(wr_p), .wr_addr(row_cnt_q), .wr_data(row_data),
      .rd_en(rd_ip), .rd_addr(row_cnt_d), .rd_data(p_rd));

   // Job-done cycle holds off a new command so acceptance starts the cycle after.
   assign cmd_ready         = (state_q == IDLE) && !job_done_q;
   assign row_ready         = (state_q == LOAD_W) || (state_q == LOAD_I) || (state_q == LOAD_P);
   assign busy              = (state_q != IDLE);
   assign job_done          = job_done_q;
   assign weight_en         = weight_en_q;
   assign input_en          = ip_en_q;
   assign partial_en        = ip_en_q;
   assign row_in_en         = row_in_q;
   assign row_ps_en         = row_ps_q;
   assign array_in          = w_rd | i_rd;
   assign array_in_partials = p_rd;
endmodule

// File: tb/tb_systolic_array_feeder.sv
// Directed bench: one GAP=1 feeder and one GAP=0 feeder, selected by sel.
module tb_systolic_array_feeder;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int RW = 2;
   localparam int W  = N * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, sel, cmd_valid, cmd_has_weights, row_valid, drained, fifo_has_space;
   logic [W-1:0] row_data;

   logic a_cmd_ready, a_row_ready, a_we, a_ie, a_pe, a_busy, a_done;
   logic [RW-1:0] a_rin, a_rps;
   logic [W-1:0]  a_ain, a_aps;
   logic b_cmd_ready, b_row_ready, b_we, b_ie, b_pe, b_busy, b_done;
   logic [RW-1:0] b_rin, b_rps;
   logic [W-1:0]  b_ain, b_aps;

   systolic_array_feeder #(.N(N), .DW(DW), .GAP(1)) dut_a (
      .clk(clk), .RST(rst), .cmd_valid(sel & cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_has_weights(cmd_has_weights), .row_valid(sel & row_valid), .row_ready(a_row_ready),
      .row_data(row_data), .weight_en(a_we), .input_en(a_ie), .partial_en(a_pe),
      .row_in_en(a_rin), .row_ps_en(a_rps), .array_in(a_ain), .array_in_partials(a_aps),
      .drained(drained), .fifo_has_space(fifo_has_space), .busy(a_busy), .job_done(a_done));

   systolic_array_feeder #(.N(N), .DW(DW), .GAP(0)) dut_b (
      .clk(clk), .RST(rst), .cmd_valid(!sel & cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_has_weights(cmd_has_weights), .row_valid(!sel & row_valid), .row_ready(b_row_ready),
      .row_data(row_data), .weight_en(b_we), .input_en(b_ie), .partial_en(b_pe),
      .row_in_en(b_rin), .row_ps_en(b_rps), .array_in(b_ain), .array_in_partials(b_aps),
      .drained(drained), .fifo_has_space(fifo_has_space), .busy(b_busy), .job_done(b_done));

   logic m_cmd_ready, m_row_ready, m_we, m_ie, m_pe, m_busy, m_done;
   logic [RW-1:0] m_rin, m_rps;
   logic [W-1:0]  m_ain, m_aps;
   assign m_cmd_ready = sel ? a_cmd_ready : b_cmd_ready;
   assign m_row_ready = sel ? a_row_ready : b_row_ready;
   assign m_we   = sel ? a_we   : b_we;
   assign m_ie   = sel ? a_ie   : b_ie;
   assign m_pe   = sel ? a_pe   : b_pe;
   assign m_busy = sel ? a_busy : b_busy;
   assign m_done = sel ? a_done : b_done;
   assign m_rin  = sel ? a_rin  : b_rin;
   assign m_rps  = sel ? a_rps  : b_rps;
   assign m_ain  = sel ? a_ain  : b_ain;
   assign m_aps  = sel ? a_aps  : b_aps;

   typedef struct {
      int            cyc;
      logic          w;
      logic          i;
      logic          p;
      logic [RW-1:0] rin;
      logic [RW-1:0] rps;
      logic [W-1:0]  ain;
      logic [W-1:0]  aps;
   } ev_t;

   ev_t log_q[$];
   int  cyc = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  bad_idle = 0;
   int  passed = 0;
   int  total = 0;

   logic [W-1:0] Wm [N];
   logic [W-1:0] Im [N];
   logic [W-1:0] Pm [N];

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe log of the selected feeder; data/index nonzero without a strobe is tallied.
   always @(negedge clk) begin
      if (m_we || m_ie || m_pe)
         log_q.push_back('{cyc, m_we, m_ie, m_pe, m_rin, m_rps, m_ain, m_aps});
      else if (m_rin != '0 || m_rps != '0 || m_ain != '0 || m_aps != '0)
         bad_idle++;
      if (m_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   function automatic logic [W-1:0] mkrow(input int base_v, input int stride, input int i);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < N; j++) r[(N-1-j)*DW +: DW] = DW'(base_v + stride * i + j);
      return r;
   endfunction

   task automatic do_cmd(input logic hw);
      int t;
      t = 0;
      cmd_valid = 1'b1;
      cmd_has_weights = hw;
      while (!m_cmd_ready && t < 100) begin tick(1); t++; end
      chk("cmd_wait_bound", W'(t < 100), W'(1));
      tick(1);
      cmd_valid = 1'b0;
      cmd_has_weights = 1'b0;
   endtask

   task automatic send_row(input logic [W-1:0] d, input int bub);
      int t;
      t = 0;
      row_valid = 1'b0;
      if (bub > 0) tick(bub);
      row_valid = 1'b1;
      row_data = d;
      while (!m_row_ready && t < 100) begin tick(1); t++; end
      chk("row_wait_bound", W'(t < 100), W'(1));
      tick(1);
      row_valid = 1'b0;
      row_data = '0;
   endtask

   task automatic load_rows(input logic hw, input int bub);
      if (hw) for (int i = 0; i < N; i++) send_row(Wm[i], bub);
      for (int i = 0; i < N; i++) send_row(Im[i], bub);
      for (int i = 0; i < N; i++) send_row(Pm[i], bub);
   endtask

   task automatic wait_done(input int dbase);
      int t;
      t = 0;
      while (done_cnt == dbase && t < 200) begin tick(1); t++; end
      chk("done_wait_bound", W'(t < 200), W'(1));
      tick(1);
   endtask

   task automatic check_job(input string tag, input logic hw, input int gap, input int start,
                            input int base, input int dbase, input int bbase);
      int nw, r;
      ev_t e;
      nw = hw ? N : 0;
      chk({tag, "_nev"}, W'(log_q.size() - base), W'(nw + N));
      chk({tag, "_done_cnt"}, W'(done_cnt - dbase), W'(1));
      chk({tag, "_done_cyc"}, W'(done_cyc), W'(start + nw + N * (1 + gap)));
      chk({tag, "_idle_zero"}, W'(bad_idle - bbase), W'(0));
      for (int k = 0; k < nw + N && base + k < log_q.size(); k++) begin
         e = log_q[base + k];
         if (k < nw) begin
            r = k;
            chk({tag, "_w_ctl"}, W'({e.w, e.i, e.p, e.rin, e.rps}), W'({3'b100, RW'(r), RW'(0)}));
            chk({tag, "_w_cyc"}, W'(e.cyc), W'(start + k));
            chk({tag, "_w_data"}, e.ain, Wm[r]);
            chk({tag, "_w_part"}, e.aps, W'(0));
         end else begin
            r = k - nw;
            chk({tag, "_ip_ctl"}, W'({e.w, e.i, e.p, e.rin, e.rps}), W'({3'b011, RW'(r), RW'(r)}));
            chk({tag, "_ip_cyc"}, W'(e.cyc), W'(start + nw + r * (1 + gap)));
            chk({tag, "_ip_in"}, e.ain, Im[r]);
            chk({tag, "_ip_part"}, e.aps, Pm[r]);
         end
      end
   endtask

   initial begin
      int base, dbase, bbase, start, t, early;
      rst = 1'b1; sel = 1'b1; cmd_valid = 1'b0; cmd_has_weights = 1'b0;
      row_valid = 1'b0; row_data = '0; drained = 1'b0; fifo_has_space = 1'b0;
      tick(3);
      chk("rst_cmd_ready", W'(a_cmd_ready), W'(1));
      chk("rst_busy", W'(a_busy), W'(0));
      chk("rst_strobes", W'({a_we, a_ie, a_pe, a_done, a_row_ready}), W'(0));
      chk("rst_data", a_ain | a_aps | W'({a_rin, a_rps}), W'(0));
      chk("rst_b_cmd_ready", W'(b_cmd_ready), W'(1));
      rst = 1'b0;
      tick(1);

      // Weight job: W[i][j]=4i+j, identity inputs, zero partials, drained after 3 cycles.
      for (int i = 0; i < N; i++) begin
         Wm[i] = mkrow(0, 4, i);
         Im[i] = '0;
         Im[i][(N-1-i)*DW] = 1'b1;
         Pm[i] = '0;
      end
      base = log_q.size(); dbase = done_cnt; bbase = bad_idle;
      do_cmd(1'b1);
      load_rows(1'b1, 0);
      tick(3);
      chk("wjob_hold_nev", W'(log_q.size() - base), W'(0));
      drained = 1'b1;
      start = cyc + 1;
      wait_done(dbase);
      check_job("wjob", 1'b1, 1, start, base, dbase, bbase);
      if (log_q.size() > base)
         chk("wjob_row0_lit", log_q[base].ain, 128'h00000000_00000001_00000002_00000003);
      drained = 1'b0;

      // Input-only job held off by fifo_has_space for 5 cycles.
      for (int i = 0; i < N; i++) begin
         Im[i] = mkrow(100, 10, i);
         Pm[i] = mkrow(200, 10, i);
      end
      base = log_q.size(); dbase = done_cnt; bbase = bad_idle;
      do_cmd(1'b0);
      load_rows(1'b0, 0);
      tick(5);
      chk("space_hold_nev", W'(log_q.size() - base), W'(0));
      fifo_has_space = 1'b1;
      start = cyc + 1;
      wait_done(dbase);
      check_job("ionly", 1'b0, 1, start, base, dbase, bbase);
      fifo_has_space = 1'b0;

      // Row_valid toggled every other cycle; drained already high gives a 0-cycle wait.
      for (int i = 0; i < N; i++) Wm[i] = mkrow(300, 10, i);
      drained = 1'b1;
      base = log_q.size(); dbase = done_cnt; bbase = bad_idle;
      do_cmd(1'b1);
      load_rows(1'b1, 1);
      start = cyc + 1;
      wait_done(dbase);
      check_job("toggle", 1'b1, 1, start, base, dbase, bbase);
      if (log_q.size() > base + N + 2)
         chk("toggle_I2_lit", log_q[base + N + 2].ain, 128'h00000078_00000079_0000007a_0000007b);

      // Reset while input row 1 is on the outputs, then a clean input-only job.
      for (int i = 0; i < N; i++) Wm[i] = mkrow(500, 10, i);
      do_cmd(1'b1);
      load_rows(1'b1, 0);
      t = 0;
      while (!(m_ie && m_rin == RW'(1)) && t < 100) begin tick(1); t++; end
      chk("rst_mid_wait_bound", W'(t < 100), W'(1));
      rst = 1'b1;
      tick(1);
      chk("rst_mid_strobes", W'({a_we, a_ie, a_pe, a_done}), W'(0));
      chk("rst_mid_cmd_ready", W'(a_cmd_ready), W'(1));
      chk("rst_mid_busy", W'(a_busy), W'(0));
      chk("rst_mid_data", a_ain | a_aps | W'({a_rin, a_rps}), W'(0));
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         Im[i] = mkrow(700, 10, i);
         Pm[i] = mkrow(800, 10, i);
      end
      fifo_has_space = 1'b1;
      tick(1);
      base = log_q.size(); dbase = done_cnt; bbase = bad_idle;
      do_cmd(1'b0);
      load_rows(1'b0, 0);
      start = cyc + 1;
      wait_done(dbase);
      check_job("post_rst", 1'b0, 1, start, base, dbase, bbase);

      // Back-to-back: weight job, then input-only command held pending.
      fifo_has_space = 1'b0;
      drained = 1'b1;
      for (int i = 0; i < N; i++) begin
         Wm[i] = mkrow(900, 10, i);
         Im[i] = mkrow(1000, 10, i);
         Pm[i] = mkrow(1100, 10, i);
      end
      base = log_q.size(); dbase = done_cnt; bbase = bad_idle;
      do_cmd(1'b1);
      load_rows(1'b1, 0);
      start = cyc + 1;
      cmd_valid = 1'b1;
      cmd_has_weights = 1'b0;
      early = 0; t = 0;
      while (done_cnt == dbase && t < 200) begin
         if (m_cmd_ready) early++;
         tick(1);
         t++;
      end
      chk("b2b_done_bound", W'(t < 200), W'(1));
      chk("b2b_ready_early", W'(early), W'(0));
      chk("b2b_ready_at_done", W'(m_cmd_ready), W'(0));
      tick(1);
      chk("b2b_ready_after", W'(m_cmd_ready), W'(1));
      tick(1);
      cmd_valid = 1'b0;
      chk("b2b_accepted", W'(m_busy), W'(1));
      check_job("b2b_j1", 1'b1, 1, start, base, dbase, bbase);
      base = log_q.size(); dbase = done_cnt; bbase = bad_idle;
      load_rows(1'b0, 0);
      tick(2);
      chk("b2b_j2_space_hold", W'(log_q.size() - base), W'(0));
      fifo_has_space = 1'b1;
      start = cyc + 1;
      wait_done(dbase);
      check_job("b2b_j2", 1'b0, 1, start, base, dbase, bbase);

      // GAP=0 build: input/partial rows on consecutive cycles.
      sel = 1'b0;
      tick(1);
      base = log_q.size(); dbase = done_cnt; bbase = bad_idle;
      do_cmd(1'b0);
      load_rows(1'b0, 0);
      start = cyc + 1;
      wait_done(dbase);
      check_job("gap0", 1'b0, 0, start, base, dbase, bbase);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
